// File: rtl/inst_rom_loader.sv
// Instruction ROM for the openmips fetch port, filled through a byte-wide load port.
// Holds the core in reset until the image is complete. `INST_ROM_CSUM_EN enables the load checksum.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic [7:0]        ld_csum_o,
  output logic              cpu_rst_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     part_q, part_d;

  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] wptr_inc;
  logic            accept;
  logic            mem_we;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem [DEPTH];

  logic [ADDR_W-1:0] rd_idx;
  logic              rd_hit;
  logic              unused_addr_lsbs;

`ifdef INST_ROM_CSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign len_clamped = (ld_len_i > LEN_MAX) ? LEN_MAX : ld_len_i;
  assign wptr_inc    = wptr_q + (ADDR_W + 1)'(1);
  assign accept      = ld_valid_i && ld_ready_o;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wptr_q  <= '0;
      bcnt_q  <= '0;
      part_q  <= '0;
`ifdef INST_ROM_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      bcnt_q  <= bcnt_d;
      part_q  <= part_d;
`ifdef INST_ROM_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto RAM; len_q = 0 hides stale words.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[ADDR_W-1:0]] <= mem_wdata;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wptr_d    = wptr_q;
    bcnt_d    = bcnt_q;
    part_d    = part_q;
    mem_we    = 1'b0;
    mem_wdata = {part_q, ld_byte_i};
`ifdef INST_ROM_CSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (ld_start_i) begin
          len_d   = len_clamped;
          wptr_d  = '0;
          bcnt_d  = '0;
          state_d = (len_clamped != '0) ? ST_LOAD : ST_RUN;
`ifdef INST_ROM_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
`ifdef INST_ROM_CSUM_EN
          csum_d = csum_q + ld_byte_i;
`endif
          if (bcnt_q == 2'd3) begin
            // Fourth byte completes the big-endian word; the last word also releases the core.
            mem_we = 1'b1;
            wptr_d = wptr_inc;
            bcnt_d = '0;
            if (wptr_inc == len_q) state_d = ST_RUN;
          end else begin
            part_d = {part_q[15:0], ld_byte_i};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    ld_ready_o = (state_q == ST_LOAD);
    ld_done_o  = (state_q == ST_RUN);
    cpu_rst_o  = (state_q != ST_RUN);
  end

`ifdef INST_ROM_CSUM_EN
  assign ld_csum_o = csum_q;
`else
  assign ld_csum_o = 8'h00;
`endif

  // Zero-latency read; anything outside the loaded image reads as a NOP.
  assign rd_idx           = rom_addr_i[ADDR_W+1:2];
  assign unused_addr_lsbs = ^rom_addr_i[1:0];
  assign rd_hit           = rom_ce_i && (state_q == ST_RUN) &&
                            (rom_addr_i[31:ADDR_W+2] == '0) &&
                            ({1'b0, rd_idx} < len_q);
  assign rom_data_o       = rd_hit ? mem[rd_idx] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: read-vector table, load scoreboard and corner sequences.
module tb_inst_rom_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce;
  logic [31:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_ready;
  logic          ld_done;
  logic [7:0]    ld_csum;
  logic          cpu_rst;

  typedef struct {
    int          idx;
    logic [31:0] word;
  } sb_t;

  typedef struct {
    string       name;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vt[6];
  logic [31:0] lw[16];
  int          n_err = 0;
  int          n_chk = 0;

  inst_rom_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce),
    .rom_addr_i (rom_addr),
    .rom_data_o (rom_data),
    .ld_start_i (ld_start),
    .ld_len_i   (ld_len),
    .ld_valid_i (ld_valid),
    .ld_byte_i  (ld_byte),
    .ld_ready_o (ld_ready),
    .ld_done_o  (ld_done),
    .ld_csum_o  (ld_csum),
    .cpu_rst_o  (cpu_rst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW:0] len);
    ld_start = 1'b1;
    ld_len   = len;
    step();
    ld_start = 1'b0;
  endtask

  // Sends n words from lw[] one byte per cycle; 3 idle cycles follow byte number gap_at.
  task automatic load_words(input int n, input int gap_at, input int exp_cycles);
    int steps = 0;
    int first_done = -1;
    for (int k = 0; k < 4 * n; k++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'(lw[k / 4] >> (8 * (3 - (k % 4))));
      if (k % 4 == 3) sb_q.push_back('{idx: k / 4, word: lw[k / 4]});
      step();
      steps++;
      if (ld_done && first_done < 0) first_done = steps;
      ld_valid = 1'b0;
      if (k == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          ld_byte  = 8'hEE;
          step();
          steps++;
          if (ld_done && first_done < 0) first_done = steps;
        end
      end
    end
    check("run_entry_cycle", 32'(first_done), 32'(exp_cycles));
    check("cpu_rst_in_run", 32'(cpu_rst), 32'd0);
    check("ready_in_run", 32'(ld_ready), 32'd0);
  endtask

  task automatic drain_sb();
    sb_t e;
    rom_ce = 1'b1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rom_addr = 32'(e.idx) << 2;
      #1;
      check($sformatf("sb_word%0d", e.idx), rom_data, e.word);
    end
  endtask

  initial begin
    vt[0] = '{name: "read_idx2_unloaded", ce: 1'b1, addr: 32'h0000_0008, exp: 32'h0};
    vt[1] = '{name: "read_high_addr",     ce: 1'b1, addr: 32'h1000_0000, exp: 32'h0};
    vt[2] = '{name: "read_alias_bit6",    ce: 1'b1, addr: 32'h0000_0040, exp: 32'h0};
    vt[3] = '{name: "read_ce_low",        ce: 1'b0, addr: 32'h0000_0000, exp: 32'h0};
    vt[4] = '{name: "read_lsbs_ignored",  ce: 1'b1, addr: 32'h0000_0003, exp: 32'h3402_0011};
    vt[5] = '{name: "read_word1_lsbs",    ce: 1'b1, addr: 32'h0000_0006, exp: 32'h3403_0022};

    rst = 1'b1; rom_ce = 1'b1; rom_addr = '0;
    ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_byte = '0;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_done", 32'(ld_done), 32'd0);
    check("rst_csum", 32'(ld_csum), 32'd0);
    check("rst_rom_data", rom_data, 32'h0);

    // Basic two-word load
    lw[0] = 32'h3402_0011; lw[1] = 32'h3403_0022;
    do_start(5'd2);
    check("load_ready", 32'(ld_ready), 32'd1);
    check("load_cpu_rst", 32'(cpu_rst), 32'd1);
    load_words(2, -1, 8);
    drain_sb();
    for (int i = 0; i < 6; i++) begin
      rom_ce = vt[i].ce;
      rom_addr = vt[i].addr;
      #1;
      check(vt[i].name, rom_data, vt[i].exp);
    end
    rom_ce = 1'b1;

    // Restart from RUN with back-pressure between bytes 2 and 3
    lw[0] = 32'hA1B2_C3D4; lw[1] = 32'h0F1E_2D3C;
    do_start(5'd2);
    rom_addr = '0;
    #1;
    check("reassert_cpu_rst", 32'(cpu_rst), 32'd1);
    check("load_read_blocked", rom_data, 32'h0);
    load_words(2, 1, 11);
    drain_sb();

    // Reset after 5 bytes of a 4-word load
    do_start(5'd4);
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1;
      ld_byte = 8'(8'h50 + k);
      step();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rom_addr = '0;
    #1;
    check("abort_ready", 32'(ld_ready), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_read0", rom_data, 32'h0);
    rom_addr = 32'h4;
    #1;
    check("abort_read1", rom_data, 32'h0);
    lw[0] = 32'h1111_2222; lw[1] = 32'h3333_4444; lw[2] = 32'h5555_6666; lw[3] = 32'h7777_8888;
    do_start(5'd4);
    load_words(4, -1, 16);
    drain_sb();

    // Zero-length start from IDLE, then restart from RUN with len = 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_start(5'd0);
    check("len0_done", 32'(ld_done), 32'd1);
    check("len0_cpu_rst", 32'(cpu_rst), 32'd0);
    rom_addr = 32'h0;
    #1;
    check("len0_read0", rom_data, 32'h0);
    rom_addr = 32'h4;
    #1;
    check("len0_read1", rom_data, 32'h0);
    do_start(5'd1);
    check("len1_cpu_rst", 32'(cpu_rst), 32'd1);
    check("len1_ready", 32'(ld_ready), 32'd1);
    lw[0] = 32'hFF01_1020;
    load_words(1, -1, 4);
`ifdef INST_ROM_CSUM_EN
    check("csum", 32'(ld_csum), 32'h30);
`else
    check("csum", 32'(ld_csum), 32'h00);
`endif
    drain_sb();

    // Oversized length clamps to full memory
    for (int i = 0; i < 16; i++) lw[i] = {8'(i), 8'hA5, 8'(~i), 8'h5A};
    do_start(5'd31);
    load_words(16, -1, 64);
    drain_sb();
    rom_addr = 32'h40;
    #1;
    check("full_alias_read", rom_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the `openmips` core's fetch port: it answers `rom_ce`/`rom_addr` requests with the 32-bit instruction word in the same cycle. It also owns a byte-wide load port that fills the memory before execution, and it holds the core in reset until loading completes. It sits beside `openmips` in the SoC top: its `cpu_rst_o` drives the core's `rst`, and its read port faces the core's `rom_*` signals.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; capacity is 2^ADDR_W words.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rom_ce_i` input 1: fetch enable from the core.
- `rom_addr_i` input 32: byte address from the core's PC.
- `rom_data_o` output 32: instruction word returned to the core.
- `ld_start_i` input 1: begin a load session; sampled in IDLE and RUN.
- `ld_len_i` input ADDR_W+1: number of words to load, latched on start.
- `ld_valid_i` input 1: a byte is present on `ld_byte_i`.
- `ld_byte_i` input 8: load data byte.
- `ld_ready_o` output 1: the block accepts a byte this cycle.
- `ld_done_o` output 1: the memory image is valid (state RUN).
- `ld_csum_o` output 8: checksum of loaded bytes; only meaningful with `INST_ROM_CSUM_EN` (see Configuration).
- `cpu_rst_o` output 1: reset for the core; high except in RUN.

## Operation
- States: IDLE, LOAD, RUN.
- **Reset.** `rst` forces IDLE and clears the write pointer `wptr`, byte counter `bcnt`, latched length `len` and checksum. Output reset values:
  - `cpu_rst_o` = 1, `ld_ready_o` = 0, `ld_done_o` = 0, `ld_csum_o` = 0, `rom_data_o` = 0.
  - Memory array contents are not reset.
- **IDLE.**
  - `ld_start_i` with `ld_len_i` ≠ 0: latch `len`, clear `wptr`/`bcnt`/checksum, go to LOAD.
  - `ld_start_i` with `ld_len_i` = 0: go directly to RUN with `len` = 0.
- **LOAD.**
  - `ld_ready_o` = 1.
  - A byte is accepted when `ld_valid_i && ld_ready_o`. Accepted bytes assemble big-endian: the first byte goes to bits 31:24, the fourth to bits 7:0.
  - On the 4th accepted byte: write the assembled word to `mem[wptr]`, increment `wptr`, reset `bcnt` to 0.
  - If the incremented `wptr` equals `len`, go to RUN on the same edge.
  - `ld_start_i` is ignored in LOAD.
- **RUN.**
  - `cpu_rst_o` = 0, `ld_done_o` = 1, `ld_ready_o` = 0.
  - `ld_start_i` returns the block to LOAD (or straight to RUN if the new length is 0) with the same latching as in IDLE. `cpu_rst_o` re-asserts on the next cycle.
- **Read port (combinational).**
  - Word index `idx` = `rom_addr_i[ADDR_W+1:2]`.
  - `rom_data_o = mem[idx]` only when all of the following hold: `rom_ce_i` = 1, state is RUN, `rom_addr_i[31:ADDR_W+2]` = 0, and `idx` < `len`.
  - Otherwise `rom_data_o` = 0 (reads as a NOP).
  - `rom_addr_i[1:0]` is ignored.
- **Width rules.** `len` is ADDR_W+1 bits, so a full memory (`len` = 2^ADDR_W) is representable. `ld_len_i` > 2^ADDR_W is clamped to 2^ADDR_W. `wptr` never wraps.

## Timing
- Read latency is 0 cycles: the combinational path from `rom_addr_i` to `rom_data_o` lets the core's IF/ID register capture the word on the same edge the PC presents it.
- One byte is accepted per cycle at most. Minimum load time is 4·`len` cycles plus 1 cycle for the start.
- The last word's write and the LOAD→RUN transition occur on the same edge. `cpu_rst_o` falls on that edge, so the core's first fetch (PC = 0) sees the complete image.
- `ld_ready_o` is a registered state decode; it never depends combinationally on `ld_valid_i`.
- `rst` during LOAD aborts the session. The partial image is unreadable because `len` = 0, and the core stays in reset.
- `ld_valid_i` outside LOAD has no effect.

## Configuration
- `INST_ROM_CSUM_EN` defined:
  - `ld_csum_o` holds the modulo-256 sum of every byte accepted in the current session.
  - It is cleared on each start, holds its value in RUN, and updates one cycle after each accepted byte.
- `INST_ROM_CSUM_EN` undefined: the port remains, tied to 8'h00, and no adder is synthesized.

## Test plan
- Reset then idle 5 cycles: `cpu_rst_o` = 1, `ld_ready_o` = 0, `rom_data_o` = 0 with `rom_ce_i` = 1 and `rom_addr_i` = 0.
- Start with `len` = 2, bytes 34 02 00 11 / 34 03 00 22 (one per cycle): RUN is entered on the 8th accepted byte's edge. Then `rom_addr_i` = 0 returns 32'h34020011, `rom_addr_i` = 4 returns 32'h34030022, `rom_addr_i` = 8 returns 0, `rom_addr_i` = 32'h1000_0000 returns 0.
- Back-pressure: drop `ld_valid_i` for 3 cycles between bytes 2 and 3 of word 0. The assembled word is unchanged, and RUN is entered 3 cycles later than in the previous case.
- Assert `rst` after 5 bytes of a `len` = 4 load: IDLE, `cpu_rst_o` = 1, all reads return 0. A restart then loads correctly from word 0.
- `ld_start_i` with `len` = 0: RUN on the next cycle and every read returns 0. A start in RUN with `len` = 1 re-asserts `cpu_rst_o` the following cycle.
- With `INST_ROM_CSUM_EN`: bytes FF 01 10 20 give `ld_csum_o` = 8'h30. Without the macro, the same load gives `ld_csum_o` = 8'h00.
